// File: rtl/ccff_loader_if.sv
`timescale 1ns/1ps
// Byte-stream handshake between the host controller (master) and the config-chain loader (slave).
interface ccff_loader_if;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;

    modport master (output din, output din_valid, input din_ready);
    modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/ccff_loader.sv
`timescale 1ns/1ps
// ccff_loader: serialises a byte stream MSB-first onto the fabric ccff_head with a per-bit shift enable.
// Define CCFF_LOADER_CRC_EN to append a CRC-16-CCITT check of the shifted bits before DONE.
module ccff_loader #(
    parameter int CHAIN_LEN = 1024,
    parameter int CNT_W     = 16
) (
    input  logic         prog_clk,
    input  logic         reset,
    input  logic         start,
    input  logic         abort,
    ccff_loader_if.slave dbus,
    output logic         ccff_head,
    output logic         ccff_shift,
    output logic         busy,
    output logic         done,
    output logic         error
);

    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] NUM_BYTES = CNT_W'((CHAIN_LEN + 7) / 8);

`ifdef CCFF_LOADER_CRC_EN
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CRC, S_DONE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [7:0]       hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       shift_cnt_q, shift_cnt_d;
    logic             ccff_head_q, ccff_head_d;
    logic             ccff_shift_q, ccff_shift_d;

    logic chain_full, load_ready, crc_ready, xfer, present, take_hold, bit_val, restart;

`ifdef CCFF_LOADER_CRC_EN
    logic [15:0] crc_q, crc_d;
    logic [7:0]  crc_hi_q, crc_hi_d;
    logic        crc_cnt_q, crc_cnt_d;
    logic        error_q, error_d;
    logic        crc_fb;
    assign crc_ready = (state_q == S_CRC);
`else
    assign crc_ready = 1'b0;
`endif

    assign chain_full = (bit_cnt_q == LAST_CNT);
    // The holding reg may refill on the same edge it hands its byte to the empty shift reg.
    assign load_ready = (state_q == S_LOAD) && (!hold_full_q || shift_cnt_q == 3'd0)
                        && (byte_cnt_q != NUM_BYTES);
    assign dbus.din_ready = load_ready | crc_ready;
    assign xfer      = dbus.din_valid & dbus.din_ready;
    assign present   = (state_q == S_LOAD) && !chain_full && (shift_cnt_q != 3'd0 || hold_full_q);
    assign take_hold = present && (shift_cnt_q == 3'd0);
    assign bit_val   = take_hold ? hold_q[7] : shift_q[7];
    assign restart   = (state_q == S_IDLE || state_q == S_DONE) && start;

    // FSM state register
    always_ff @(posedge prog_clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: if (start) state_d = S_LOAD;
`ifdef CCFF_LOADER_CRC_EN
                S_LOAD: if (chain_full) state_d = S_CRC;
                S_CRC:  if (xfer && crc_cnt_q) state_d = S_DONE;
`else
                S_LOAD: if (chain_full) state_d = S_DONE;
`endif
                default: state_d = S_IDLE;
            endcase
        end
    end

    // FSM outputs
    always_comb begin
`ifdef CCFF_LOADER_CRC_EN
        busy  = (state_q == S_LOAD) || (state_q == S_CRC);
        error = error_q;
`else
        busy  = (state_q == S_LOAD);
        error = 1'b0;
`endif
        done       = (state_q == S_DONE);
        ccff_head  = ccff_head_q;
        ccff_shift = ccff_shift_q;
    end

    // Datapath next-state
    always_comb begin
        bit_cnt_d    = bit_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        hold_d       = hold_q;
        hold_full_d  = hold_full_q;
        shift_d      = shift_q;
        shift_cnt_d  = shift_cnt_q;
        ccff_head_d  = ccff_head_q;
        ccff_shift_d = 1'b0;
`ifdef CCFF_LOADER_CRC_EN
        crc_d     = crc_q;
        crc_hi_d  = crc_hi_q;
        crc_cnt_d = crc_cnt_q;
        error_d   = error_q;
        crc_fb    = crc_q[15] ^ bit_val;
`endif
        if (abort) begin
`ifdef CCFF_LOADER_CRC_EN
            error_d = 1'b0;
`endif
        end else if (restart) begin
            bit_cnt_d   = '0;
            byte_cnt_d  = '0;
            hold_full_d = 1'b0;
            shift_cnt_d = 3'd0;
`ifdef CCFF_LOADER_CRC_EN
            crc_d     = 16'hFFFF;
            crc_cnt_d = 1'b0;
            error_d   = 1'b0;
`endif
        end else begin
            if (present) begin
                ccff_shift_d = 1'b1;
                ccff_head_d  = bit_val;
                bit_cnt_d    = bit_cnt_q + CNT_W'(1);
`ifdef CCFF_LOADER_CRC_EN
                crc_d = {crc_q[14:0], 1'b0} ^ (crc_fb ? 16'h1021 : 16'h0000);
`endif
                if (take_hold) begin
                    shift_d     = {hold_q[6:0], 1'b0};
                    shift_cnt_d = 3'd7;
                    hold_full_d = 1'b0;
                end else begin
                    shift_d     = {shift_q[6:0], 1'b0};
                    shift_cnt_d = shift_cnt_q - 3'd1;
                end
                // Unused LSBs of the final byte are dropped once the chain is full.
                if (bit_cnt_q + CNT_W'(1) == LAST_CNT) begin
                    shift_cnt_d = 3'd0;
                    hold_full_d = 1'b0;
                end
            end
            if (xfer && load_ready) begin
                hold_d      = dbus.din;
                hold_full_d = 1'b1;
                byte_cnt_d  = byte_cnt_q + CNT_W'(1);
            end
`ifdef CCFF_LOADER_CRC_EN
            if (xfer && crc_ready) begin
                if (!crc_cnt_q) begin
                    crc_hi_d  = dbus.din;
                    crc_cnt_d = 1'b1;
                end else begin
                    error_d = ({crc_hi_q, dbus.din} != crc_q);
                end
            end
`endif
        end
    end

    always_ff @(posedge prog_clk or negedge reset) begin
        if (!reset) begin
            bit_cnt_q    <= '0;
            byte_cnt_q   <= '0;
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            shift_q      <= '0;
            shift_cnt_q  <= 3'd0;
            ccff_head_q  <= 1'b0;
            ccff_shift_q <= 1'b0;
        end else begin
            bit_cnt_q    <= bit_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            shift_q      <= shift_d;
            shift_cnt_q  <= shift_cnt_d;
            ccff_head_q  <= ccff_head_d;
            ccff_shift_q <= ccff_shift_d;
        end
    end

`ifdef CCFF_LOADER_CRC_EN
    always_ff @(posedge prog_clk or negedge reset) begin
        if (!reset) begin
            crc_q     <= 16'hFFFF;
            crc_hi_q  <= '0;
            crc_cnt_q <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            crc_q     <= crc_d;
            crc_hi_q  <= crc_hi_d;
            crc_cnt_q <= crc_cnt_d;
            error_q   <= error_d;
        end
    end
`endif

endmodule

// File: tb/tb_ccff_loader.sv
`timescale 1ns/1ps
// Directed bench for ccff_loader (CHAIN_LEN=20); CRC vectors run only when CCFF_LOADER_CRC_EN is defined.
module tb_ccff_loader;
    localparam int CL = 20;

    logic prog_clk = 1'b0;
    logic rst_n    = 1'b1;
    logic start    = 1'b0;
    logic abort    = 1'b0;
    logic ccff_head, ccff_shift, busy, done, error;

    ccff_loader_if ifc ();

    ccff_loader #(.CHAIN_LEN(CL), .CNT_W(16)) dut (
        .prog_clk   (prog_clk),
        .reset      (rst_n),
        .start      (start),
        .abort      (abort),
        .dbus       (ifc),
        .ccff_head  (ccff_head),
        .ccff_shift (ccff_shift),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 prog_clk = ~prog_clk;

    int errors = 0;
    int checks = 0;

    // Chain model: captures ccff_head on every cycle the fabric clock is enabled.
    int          cyc      = 0;
    int          last_cyc = -10;
    int          cur_run  = 0;
    int          ncap     = 0;
    logic [63:0] cap      = '0;
    always @(negedge prog_clk) begin
        cyc <= cyc + 1;
        if (rst_n && ccff_shift) begin
            cap      <= {cap[62:0], ccff_head};
            ncap     <= ncap + 1;
            last_cyc <= cyc;
            cur_run  <= (last_cyc == cyc - 1) ? cur_run + 1 : 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n = 0;
        ifc.din       = b;
        ifc.din_valid = 1'b1;
        while (!ifc.din_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            check("din_ready_timeout", {31'd0, ifc.din_ready}, 32'd1);
        end else begin
            tick();
            $display("tx byte 0x%02h accepted at cycle %0d", b, cyc);
        end
        if (gap > 0) begin
            ifc.din_valid = 1'b0;
            repeat (gap) tick();
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 100) begin
            tick();
            n++;
        end
        check("done_wait", {31'd0, done}, 32'd1);
    endtask

    task automatic finish_load();
`ifdef CCFF_LOADER_CRC_EN
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        ifc.din_valid = 1'b0;
`endif
        wait_done();
    endtask

    task automatic wait_pulses(input int base, input int target);
        int n = 0;
        while (ncap - base < target && n < 60) begin
            @(negedge prog_clk);
            #1;
            n++;
        end
        check("pulse_wait", 32'(ncap - base), 32'(target));
    endtask

    task automatic check_stream(input string tag, input int base);
        check({tag, "_count"}, 32'(ncap - base), 32'd20);
        check({tag, "_bits"}, {12'd0, cap[19:0]}, 32'h000A53CF);
        check({tag, "_ready"}, {31'd0, ifc.din_ready}, 32'd0);
    endtask

    task automatic full_load();
        pulse_start();
        send_byte(8'hA5, 0);
        send_byte(8'h3C, 0);
        send_byte(8'hF0, 0);
        ifc.din_valid = 1'b0;
        finish_load();
    endtask

`ifdef CCFF_LOADER_CRC_EN
    logic start2 = 1'b0;
    logic head2, shift2, busy2, done2, err2;
    ccff_loader_if ifc2 ();
    ccff_loader #(.CHAIN_LEN(16), .CNT_W(16)) dut_crc (
        .prog_clk   (prog_clk),
        .reset      (rst_n),
        .start      (start2),
        .abort      (1'b0),
        .dbus       (ifc2),
        .ccff_head  (head2),
        .ccff_shift (shift2),
        .busy       (busy2),
        .done       (done2),
        .error      (err2)
    );

    task automatic send2(input logic [7:0] b);
        int n = 0;
        ifc2.din       = b;
        ifc2.din_valid = 1'b1;
        while (!ifc2.din_ready && n < 50) begin
            tick();
            n++;
        end
        check("crc_ready_wait", {31'd0, ifc2.din_ready}, 32'd1);
        tick();
        $display("tx crc-dut byte 0x%02h at cycle %0d", b, cyc);
    endtask

    task automatic crc_run(input logic [7:0] lo, input logic exp_err);
        int n = 0;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        send2(8'h12);
        send2(8'h34);
        send2(8'h0E);
        send2(lo);
        ifc2.din_valid = 1'b0;
        while (!done2 && n < 50) begin
            tick();
            n++;
        end
        check("crc_done", {31'd0, done2}, 32'd1);
        check("crc_error", {31'd0, err2}, {31'd0, exp_err});
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        ifc.din       = 8'h00;
        ifc.din_valid = 1'b0;
`ifdef CCFF_LOADER_CRC_EN
        ifc2.din       = 8'h00;
        ifc2.din_valid = 1'b0;
`endif
        #2 rst_n = 1'b0;
        tick();
        tick();
        check("rst_ready", {31'd0, ifc.din_ready}, 32'd0);
        check("rst_head", {31'd0, ccff_head}, 32'd0);
        check("rst_shift", {31'd0, ccff_shift}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Back-to-back stream: 20 contiguous bits, LSBs of 0xF0 discarded.
        base = ncap;
        pulse_start();
        check("start_busy", {31'd0, busy}, 32'd1);
        check("start_ready", {31'd0, ifc.din_ready}, 32'd1);
        send_byte(8'hA5, 0);
        send_byte(8'h3C, 0);
        send_byte(8'hF0, 0);
        ifc.din_valid = 1'b0;
        finish_load();
        check_stream("b2b", base);
        check("b2b_error", {31'd0, error}, 32'd0);
`ifndef CCFF_LOADER_CRC_EN
        check("b2b_no_bubble", 32'(cur_run), 32'd20);
        check("b2b_shift_fall", 32'(last_cyc), 32'(cyc - 1));
        check("b2b_shift_low", {31'd0, ccff_shift}, 32'd0);
        check("b2b_busy", {31'd0, busy}, 32'd0);
`endif
        // din_valid in DONE is refused and nothing shifts.
        base = ncap;
        ifc.din       = 8'hFF;
        ifc.din_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("done_refuse", {31'd0, ifc.din_ready}, 32'd0);
        end
        ifc.din_valid = 1'b0;
        check("done_no_shift", 32'(ncap - base), 32'd0);
        check("done_held", {31'd0, done}, 32'd1);

        // Starved stream: 2-edge latency, gaps with shift low and head held.
        base = ncap;
        pulse_start();
        send_byte(8'hA5, 0);
        ifc.din_valid = 1'b0;
        check("lat_before", {31'd0, ccff_shift}, 32'd0);
        tick();
        check("lat_shift", {31'd0, ccff_shift}, 32'd1);
        check("lat_head", {31'd0, ccff_head}, 32'd1);
        for (int i = 0; i < 12; i++) begin
            tick();
            if (i >= 8) begin
                check("gap_shift", {31'd0, ccff_shift}, 32'd0);
                check("gap_head", {31'd0, ccff_head}, 32'd1);
            end
        end
        send_byte(8'h3C, 12);
        send_byte(8'hF0, 0);
        ifc.din_valid = 1'b0;
        finish_load();
        check_stream("gap", base);
`ifndef CCFF_LOADER_CRC_EN
        check("gap_last_run", 32'(cur_run), 32'd4);
`endif

        // Asynchronous reset after 9 shifts, then reload from bit 0.
        base = ncap;
        pulse_start();
        send_byte(8'hA5, 0);
        send_byte(8'h3C, 0);
        ifc.din_valid = 1'b0;
        wait_pulses(base, 9);
        rst_n = 1'b0;
        #1;
        check("arst_ready", {31'd0, ifc.din_ready}, 32'd0);
        check("arst_head", {31'd0, ccff_head}, 32'd0);
        check("arst_shift", {31'd0, ccff_shift}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        base = ncap;
        full_load();
        check_stream("after_rst", base);

        // Abort after 4 shifts, idle refuses data, then full reload.
        base = ncap;
        pulse_start();
        send_byte(8'hA5, 0);
        ifc.din_valid = 1'b0;
        wait_pulses(base, 4);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_shift", {31'd0, ccff_shift}, 32'd0);
        base = ncap;
        ifc.din       = 8'hFF;
        ifc.din_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_refuse", {31'd0, ifc.din_ready}, 32'd0);
        end
        ifc.din_valid = 1'b0;
        check("idle_no_shift", 32'(ncap - base), 32'd0);
        base = ncap;
        full_load();
        check_stream("after_abort", base);

        // start pulsed mid-load is ignored.
        base = ncap;
        pulse_start();
        send_byte(8'hA5, 0);
        ifc.din_valid = 1'b0;
        tick();
        tick();
        pulse_start();
        check("restart_busy", {31'd0, busy}, 32'd1);
        send_byte(8'h3C, 0);
        send_byte(8'hF0, 0);
        ifc.din_valid = 1'b0;
        finish_load();
        check_stream("restart", base);

        // abort from DONE clears done.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_from_done", {31'd0, done}, 32'd0);

`ifdef CCFF_LOADER_CRC_EN
        // CRC-16-CCITT(0xFFFF) over 0x12,0x34 is 0x0EC9.
        crc_run(8'hC9, 1'b0);
        crc_run(8'hC8, 1'b1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
